// File: rtl/pulse_profile_pkg.sv
// Shared encodings, rate constants and the default profile for pulse_profile_gen.
// Also holds the saturation helper used when narrowing defaults to the configured widths.
package pulse_profile_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_RUN_CONST = 2'd1;
    localparam state_t ST_RUN_PROF  = 2'd2;
    localparam state_t ST_DONE      = 2'd3;

    localparam logic [1:0] MODE_WALK = 2'b00;
    localparam logic [1:0] MODE_JOG  = 2'b01;
    localparam logic [1:0] MODE_RUN  = 2'b10;
    localparam logic [1:0] MODE_PROF = 2'b11;

    localparam int WALK_RATE = 32;
    localparam int JOG_RATE  = 64;
    localparam int RUN_RATE  = 128;

    localparam int DEF_LEN = 12;
    localparam int DEF_RATE [DEF_LEN] = '{20, 33, 66, 27, 70, 30, 19, 30, 33, 69, 34, 124};
    localparam int DEF_DUR  [DEF_LEN] = '{ 1,  1,  1,  1,  1,  1,  1,  1,  1, 64,  6,  65};

    function automatic int sat_val(input int v, input int w);
        if (w >= 31) return v;
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    // Entries past the default list read as terminators (rate 0, duration 0).
    function automatic int def_rate(input int i);
        int r = 0;
        for (int k = 0; k < DEF_LEN; k++) if (k == i) r = DEF_RATE[k];
        return r;
    endfunction

    function automatic int def_dur(input int i);
        int d = 0;
        for (int k = 0; k < DEF_LEN; k++) if (k == i) d = DEF_DUR[k];
        return d;
    endfunction

endpackage

// File: rtl/pulse_profile_gen_profile_table.sv
// Profile segment table: register file with one write port, a read port for the
// next segment and a fixed read of segment 0; reloads the default profile on reset.
module profile_table
    import pulse_profile_pkg::*;
#(
    parameter int RATE_W  = 8,
    parameter int DUR_W   = 8,
    parameter int NUM_SEG = 16,
    parameter int ADDR_W  = $clog2(NUM_SEG)
) (
    input  logic              secondClk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [RATE_W-1:0] wr_rate,
    input  logic [DUR_W-1:0]  wr_dur,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [RATE_W-1:0] rd_rate,
    output logic [DUR_W-1:0]  rd_dur,
    output logic [RATE_W-1:0] head_rate,
    output logic [DUR_W-1:0]  head_dur
);

    logic [RATE_W-1:0] rate_mem [NUM_SEG];
    logic [DUR_W-1:0]  dur_mem  [NUM_SEG];

    // NOTE: this table is deliberately reset, since reset must restore the default
    // profile; plain data memories normally carry no reset.
    always_ff @(posedge secondClk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SEG; i++) begin
                rate_mem[i] <= RATE_W'(sat_val(def_rate(i), RATE_W));
                dur_mem[i]  <= DUR_W'(sat_val(def_dur(i), DUR_W));
            end
        end else if (we) begin
            rate_mem[wr_addr] <= wr_rate;
            dur_mem[wr_addr]  <= wr_dur;
        end
    end

    // Reads see the pre-write contents during a same-edge write.
    assign rd_rate   = rate_mem[rd_addr];
    assign rd_dur    = dur_mem[rd_addr];
    assign head_rate = rate_mem[0];
    assign head_dur  = dur_mem[0];

endmodule

// File: rtl/pulse_profile_gen.sv
// Pulse-rate profile generator clocked once per second; constant walk/jog/run rates or a table profile.
// Optional build macro PULSE_PROFILE_LOOP_EN adds a loop input that replays the profile instead of stopping.
module pulse_profile_gen
    import pulse_profile_pkg::*;
#(
    parameter int RATE_W  = 8,
    parameter int NUM_SEG = 16,
    parameter int DUR_W   = 8,
    parameter int SEC_W   = 12
) (
    input  logic                       secondClk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [1:0]                 mode,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_SEG)-1:0] cfg_addr,
    input  logic [RATE_W-1:0]          cfg_rate,
    input  logic [DUR_W-1:0]           cfg_dur,
`ifdef PULSE_PROFILE_LOOP_EN
    input  logic                       loop,
`endif
    output logic [RATE_W-1:0]          rate,
    output logic [$clog2(NUM_SEG)-1:0] seg_idx,
    output logic                       active,
    output logic                       done,
    output logic [SEC_W-1:0]           elapsed
);

    localparam int ADDR_W = $clog2(NUM_SEG);
    localparam logic [ADDR_W-1:0] LAST_SEG = ADDR_W'(NUM_SEG - 1);
    localparam logic [RATE_W-1:0] WALK_R = RATE_W'(sat_val(WALK_RATE, RATE_W));
    localparam logic [RATE_W-1:0] JOG_R  = RATE_W'(sat_val(JOG_RATE, RATE_W));
    localparam logic [RATE_W-1:0] RUN_R  = RATE_W'(sat_val(RUN_RATE, RATE_W));

    state_t              state, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [DUR_W-1:0]    remain, remain_d;
    logic [RATE_W-1:0]   rate_d, const_rate;
    logic [ADDR_W-1:0]   seg_d, next_addr;
    logic [SEC_W-1:0]    elapsed_d, elapsed_inc;
    logic [RATE_W-1:0]   rd_rate, head_rate;
    logic [DUR_W-1:0]    rd_dur, head_dur;
    logic                loop_on;

`ifdef PULSE_PROFILE_LOOP_EN
    assign loop_on = loop;
`else
    assign loop_on = 1'b0;
`endif

    profile_table #(
        .RATE_W  (RATE_W),
        .DUR_W   (DUR_W),
        .NUM_SEG (NUM_SEG),
        .ADDR_W  (ADDR_W)
    ) u_table (
        .secondClk (secondClk),
        .reset     (reset),
        .we        (cfg_we),
        .wr_addr   (cfg_addr),
        .wr_rate   (cfg_rate),
        .wr_dur    (cfg_dur),
        .rd_addr   (next_addr),
        .rd_rate   (rd_rate),
        .rd_dur    (rd_dur),
        .head_rate (head_rate),
        .head_dur  (head_dur)
    );

    assign next_addr   = seg_idx + 1'b1;
    assign elapsed_inc = (elapsed == '1) ? elapsed : elapsed + 1'b1;

    always_comb begin
        case (mode)
            MODE_WALK: const_rate = WALK_R;
            MODE_JOG:  const_rate = JOG_R;
            default:   const_rate = RUN_R;
        endcase
    end

    // NOTE: every next-state variable gets a default first so no path infers a latch;
    // combinational logic uses blocking '=', the registers below use non-blocking '<='.
    always_comb begin
        state_d   = state;
        mode_d    = mode_q;
        rate_d    = rate;
        seg_d     = seg_idx;
        remain_d  = remain;
        elapsed_d = elapsed;
        if (!start) begin
            state_d   = ST_IDLE;
            rate_d    = '0;
            seg_d     = '0;
            remain_d  = '0;
            elapsed_d = '0;
        end else if (state == ST_IDLE || mode != mode_q) begin
            // Fresh entry or restart in a newly selected mode.
            mode_d    = mode;
            seg_d     = '0;
            elapsed_d = SEC_W'(1);
            remain_d  = '0;
            if (mode != MODE_PROF) begin
                state_d = ST_RUN_CONST;
                rate_d  = const_rate;
            end else if (head_dur == '0) begin
                state_d   = ST_DONE;
                rate_d    = '0;
                elapsed_d = '0;
            end else begin
                state_d  = ST_RUN_PROF;
                rate_d   = head_rate;
                remain_d = head_dur - 1'b1;
            end
        end else begin
            case (state)
                ST_RUN_CONST: elapsed_d = elapsed_inc;
                ST_RUN_PROF: begin
                    elapsed_d = elapsed_inc;
                    if (remain != '0) begin
                        remain_d = remain - 1'b1;
                    end else if (seg_idx != LAST_SEG && rd_dur != '0) begin
                        seg_d    = next_addr;
                        rate_d   = rd_rate;
                        remain_d = rd_dur - 1'b1;
                    end else if (loop_on && head_dur != '0) begin
                        seg_d    = '0;
                        rate_d   = head_rate;
                        remain_d = head_dur - 1'b1;
                    end else begin
                        state_d   = ST_DONE;
                        rate_d    = '0;
                        elapsed_d = elapsed;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge secondClk) begin
        if (reset) begin
            state   <= ST_IDLE;
            mode_q  <= MODE_WALK;
            rate    <= '0;
            seg_idx <= '0;
            remain  <= '0;
            elapsed <= '0;
            active  <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            mode_q  <= mode_d;
            rate    <= rate_d;
            seg_idx <= seg_d;
            remain  <= remain_d;
            elapsed <= elapsed_d;
            active  <= (state_d == ST_RUN_CONST) || (state_d == ST_RUN_PROF);
            done    <= (state_d == ST_DONE);
        end
    end

endmodule

// File: tb/tb_pulse_profile_gen.sv
// Scoreboard bench for pulse_profile_gen: expected outputs are queued as stimulus is driven
// and compared one entry per clock, 1 time unit after the rising edge.
module tb_pulse_profile_gen;

    localparam int RATE_W  = 8;
    localparam int NUM_SEG = 16;
    localparam int DUR_W   = 8;
    localparam int SEC_W   = 12;
    localparam int AW      = $clog2(NUM_SEG);

    logic              secondClk = 1'b0;
    logic              reset, start, cfg_we;
    logic [1:0]        mode;
    logic [AW-1:0]     cfg_addr, seg_idx;
    logic [RATE_W-1:0] cfg_rate, rate;
    logic [DUR_W-1:0]  cfg_dur;
    logic              active, done;
    logic [SEC_W-1:0]  elapsed;
`ifdef PULSE_PROFILE_LOOP_EN
    logic              loop = 1'b0;
`endif

    pulse_profile_gen #(
        .RATE_W(RATE_W), .NUM_SEG(NUM_SEG), .DUR_W(DUR_W), .SEC_W(SEC_W)
    ) dut (
        .secondClk (secondClk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_rate  (cfg_rate),
        .cfg_dur   (cfg_dur),
`ifdef PULSE_PROFILE_LOOP_EN
        .loop      (loop),
`endif
        .rate      (rate),
        .seg_idx   (seg_idx),
        .active    (active),
        .done      (done),
        .elapsed   (elapsed)
    );

    always #5 secondClk = ~secondClk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Negative seg/el fields mean "not compared".
    typedef struct {
        string tag;
        int    rate;
        int    seg;
        int    act;
        int    dn;
        int    el;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    int def_r [12] = '{20, 33, 66, 27, 70, 30, 19, 30, 33, 69, 34, 124};
    int def_d [12] = '{ 1,  1,  1,  1,  1,  1,  1,  1,  1, 64,  6,  65};

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int r, input int s,
                              input int a, input int d, input int e);
        exp_t x;
        x.tag = tag; x.rate = r; x.seg = s; x.act = a; x.dn = d; x.el = e;
        sb.push_back(x);
    endtask

    task automatic expect_idle(input string tag);
        expect_out(tag, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        exp_t x;
        @(posedge secondClk);
        #1;
        if (sb.size() != 0) begin
            x = sb.pop_front();
            check({x.tag, ".rate"}, int'(rate), x.rate);
            check({x.tag, ".active"}, int'(active), x.act);
            check({x.tag, ".done"}, int'(done), x.dn);
            if (x.seg >= 0) check({x.tag, ".seg_idx"}, int'(seg_idx), x.seg);
            if (x.el >= 0) check({x.tag, ".elapsed"}, int'(elapsed), x.el);
        end
    endtask

    task automatic cfg_write(input int a, input int r, input int d);
        cfg_we = 1'b1; cfg_addr = AW'(a); cfg_rate = RATE_W'(r); cfg_dur = DUR_W'(d);
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; mode = 2'b00;
        cfg_we = 1'b0; cfg_addr = '0; cfg_rate = '0; cfg_dur = '0;
        tick();
        expect_idle("reset"); tick();
        reset = 1'b0;

        // Constant jog rate and elapsed counting.
        start = 1'b1; mode = 2'b01;
        for (int i = 1; i <= 5; i++) begin
            expect_out("jog", 64, 0, 1, 0, i); tick();
        end
        start = 1'b0;
        expect_idle("jog_stop"); tick();

        // Walk, then switch to run mid-run, then stop.
        start = 1'b1; mode = 2'b00;
        expect_out("walk", 32, 0, 1, 0, 1); tick();
        expect_out("walk", 32, 0, 1, 0, 2); tick();
        mode = 2'b10;
        expect_out("run_switch", 128, 0, 1, 0, 1); tick();
        start = 1'b0;
        expect_idle("run_stop"); tick();

        // Default profile end to end.
        start = 1'b1; mode = 2'b11; n = 0;
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < def_d[i]; k++) begin
                n++;
                expect_out("dflt", def_r[i], i, 1, 0, n); tick();
            end
        end
        expect_out("dflt_done", 0, -1, 0, 1, -1); tick();
        expect_out("dflt_hold", 0, -1, 0, 1, -1); tick();
        start = 1'b0;
        expect_idle("dflt_stop"); tick();

        // Short profile; write to the playing segment and a write racing the advance.
        cfg_write(0, 50, 3);
        cfg_write(1, 0, 0);
        start = 1'b1; mode = 2'b11;
        expect_out("short", 50, 0, 1, 0, 1); tick();
        cfg_we = 1'b1; cfg_addr = 0; cfg_rate = 77; cfg_dur = 5;
        expect_out("short_wr_play", 50, 0, 1, 0, 2); tick();
        cfg_we = 1'b0;
        expect_out("short", 50, 0, 1, 0, 3); tick();
        cfg_we = 1'b1; cfg_addr = 1; cfg_rate = 90; cfg_dur = 2;
        expect_out("short_race_done", 0, -1, 0, 1, -1); tick();
        cfg_we = 1'b0;
        mode = 2'b01;
        expect_out("done_mode_chg", 64, 0, 1, 0, 1); tick();
        start = 1'b0;
        expect_idle("short_stop"); tick();

        // The deferred writes are now visible.
        cfg_write(2, 0, 0);
        start = 1'b1; mode = 2'b11; n = 0;
        for (int k = 0; k < 5; k++) begin
            n++; expect_out("rewr_seg0", 77, 0, 1, 0, n); tick();
        end
        for (int k = 0; k < 2; k++) begin
            n++; expect_out("rewr_seg1", 90, 1, 1, 0, n); tick();
        end
        expect_out("rewr_done", 0, -1, 0, 1, -1); tick();
        start = 1'b0;
        expect_idle("rewr_stop"); tick();

        // Every segment used: profile must end after the last one.
        for (int i = 0; i < NUM_SEG; i++) cfg_write(i, 5 + 9 * i, 1);
        start = 1'b1; mode = 2'b11;
        for (int i = 0; i < NUM_SEG; i++) begin
            expect_out("full", 5 + 9 * i, i, 1, 0, i + 1); tick();
        end
        expect_out("full_done", 0, -1, 0, 1, -1); tick();
        start = 1'b0;
        expect_idle("full_stop"); tick();

        // Segment 0 terminator goes straight to DONE.
        cfg_write(0, 55, 0);
        start = 1'b1; mode = 2'b11;
        expect_out("seg0_term", 0, 0, 0, 1, -1); tick();
        start = 1'b0;
        expect_idle("seg0_stop"); tick();

        // Reset mid-profile with a concurrent write restores the defaults.
        cfg_write(0, 5, 4);
        start = 1'b1; mode = 2'b11;
        expect_out("pre_rst", 5, 0, 1, 0, 1); tick();
        expect_out("pre_rst", 5, 0, 1, 0, 2); tick();
        reset = 1'b1; cfg_we = 1'b1; cfg_addr = 0; cfg_rate = 99; cfg_dur = 9;
        expect_idle("mid_reset"); tick();
        reset = 1'b0; cfg_we = 1'b0; start = 1'b0;
        expect_idle("post_reset"); tick();
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_out("restored", def_r[i], i, 1, 0, i + 1); tick();
        end
        start = 1'b0;
        expect_idle("restored_stop"); tick();

`ifdef PULSE_PROFILE_LOOP_EN
        cfg_write(0, 10, 2);
        cfg_write(1, 40, 1);
        cfg_write(2, 0, 0);
        loop = 1'b1; start = 1'b1; mode = 2'b11;
        for (int i = 0; i < 7; i++) begin
            expect_out("loop", (i % 3 == 2) ? 40 : 10, (i % 3 == 2) ? 1 : 0, 1, 0, i + 1);
            tick();
        end
        start = 1'b0;
        expect_idle("loop_stop"); tick();
        cfg_write(0, 10, 0);
        start = 1'b1;
        expect_out("loop_seg0_term", 0, 0, 0, 1, -1); tick();
        start = 1'b0; loop = 1'b0;
        expect_idle("loop_term_stop"); tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
